// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The controller takes the slave side; the datapath (or a bench) takes the master side.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  dOpcode;
  logic [4:0]  dRs;
  logic [4:0]  dRt;
  logic [4:0]  xOpcode;
  logic [4:0]  xAluop;
  logic [4:0]  xRd;
  logic        branchTakenX;
  logic        mdReady;
  logic        mdException;

  logic        pcEnable;
  logic        fdEnable;
  logic        dxEnable;
  logic        xmEnable;
  logic        fdFlush;
  logic        dxFlush;
  logic        ctrlMult;
  logic        ctrlDiv;
  logic        mdBusy;
  logic        mdError;
  logic        mdTimeout;
  logic [15:0] stallCount;

  modport master (
    output dOpcode, dRs, dRt, xOpcode, xAluop, xRd, branchTakenX, mdReady, mdException,
    input  pcEnable, fdEnable, dxEnable, xmEnable, fdFlush, dxFlush,
           ctrlMult, ctrlDiv, mdBusy, mdError, mdTimeout, stallCount
  );

  modport slave (
    input  dOpcode, dRs, dRt, xOpcode, xAluop, xRd, branchTakenX, mdReady, mdException,
    output pcEnable, fdEnable, dxEnable, xmEnable, fdFlush, dxFlush,
           ctrlMult, ctrlDiv, mdBusy, mdError, mdTimeout, stallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, taken-branch squashes
// and multi-cycle mult/div stalls with error/timeout tracking and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam int         CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_md_error;
  logic             r_md_timeout;
  logic [15:0]      r_stall_cnt;

  logic w_is_mul, w_is_div, w_md_start, w_load_use, w_timeout, w_release;
  logic w_pc_en, w_fd_en, w_dx_en, w_xm_en;
  logic w_fd_flush, w_dx_flush, w_ctrl_mult, w_ctrl_div;

  assign w_is_mul   = (hz.xOpcode == OP_ALU) && (hz.xAluop == ALU_MUL);
  assign w_is_div   = (hz.xOpcode == OP_ALU) && (hz.xAluop == ALU_DIV);
  assign w_md_start = (r_state == S_IDLE) && (w_is_mul || w_is_div);
  assign w_load_use = (hz.xOpcode == OP_LW) && (hz.xRd != 5'd0) &&
                      ((hz.xRd == hz.dRs) || (hz.xRd == hz.dRt));
  // A ready result in the last allowed cycle wins over the timeout.
  assign w_timeout  = (r_state == S_WAIT) && !hz.mdReady && (r_wait_cnt == CNT_LAST);
  assign w_release  = (r_state == S_WAIT) && (hz.mdReady || w_timeout);

  // NOTE: every output is defaulted before the case so no path leaves a latch.
  always_comb begin
    w_next      = r_state;
    w_pc_en     = 1'b1;
    w_fd_en     = 1'b1;
    w_dx_en     = 1'b1;
    w_xm_en     = 1'b1;
    w_fd_flush  = 1'b0;
    w_dx_flush  = 1'b0;
    w_ctrl_mult = 1'b0;
    w_ctrl_div  = 1'b0;
    // Reset is asynchronous, so the combinational outputs must also ignore
    // the inputs while it is held, not just the registers.
    if (!reset) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_md_start) begin
            {w_pc_en, w_fd_en, w_dx_en, w_xm_en} = 4'b0000;
            w_ctrl_mult = w_is_mul;
            w_ctrl_div  = w_is_div;
            w_next      = S_WAIT;
          end else if (hz.branchTakenX) begin
            // The squash also removes any load-use consumer, so no bubble.
            w_fd_flush = 1'b1;
            w_dx_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_dx_flush = 1'b1;
          end
        end
        S_WAIT: begin
          if (w_release) begin
            w_next = S_IDLE;
          end else begin
            {w_pc_en, w_fd_en, w_dx_en, w_xm_en} = 4'b0000;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_md_error   <= 1'b0;
      r_md_timeout <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_md_start) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_release && hz.mdReady && hz.mdException) begin
        r_md_error <= 1'b1;
      end
      if (w_timeout) begin
        r_md_timeout <= 1'b1;
      end
      if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign hz.pcEnable   = w_pc_en;
  assign hz.fdEnable   = w_fd_en;
  assign hz.dxEnable   = w_dx_en;
  assign hz.xmEnable   = w_xm_en;
  assign hz.fdFlush    = w_fd_flush;
  assign hz.dxFlush    = w_dx_flush;
  assign hz.ctrlMult   = w_ctrl_mult;
  assign hz.ctrlDiv    = w_ctrl_div;
  assign hz.mdBusy     = (r_state == S_WAIT);
  assign hz.mdError    = r_md_error;
  assign hz.mdTimeout  = r_md_timeout;
  assign hz.stallCount = r_stall_cnt;

endmodule
